// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for an NDIG-digit multiplexed 7-segment display.
// Time-slices one segment bus across NDIG digit enables with leading dead
// time per slot, and double-buffers frames so swaps land on frame boundaries.
// Ports:
//   clk, rst                  clock (rising) / async active-high reset
//   enable                    1 = scan, 0 = dark and parked
//   frame_data/valid/ready    frame input handshake (digit i at [7i+6:7i])
//   segment, digit_en         display drive (zero while blanked or idle)
//   sig                       pulse on first cycle of each slot
//   frame_done                pulse on last cycle of the last slot
module seg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DWELL = 80000,
    parameter int BLANK = 16,
    parameter int CBITS = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7*NDIG-1:0] frame_data,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic [6:0]        segment,
    output logic [NDIG-1:0]   digit_en,
    output logic              sig,
    output logic              frame_done
);

    localparam int KBITS = $clog2(NDIG);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t            state, state_n;
    logic [CBITS-1:0]  cnt, cnt_n;
    logic [KBITS-1:0]  k, k_n;
    logic [7*NDIG-1:0] active;
    logic [7*NDIG-1:0] pend_buf;
    logic              pend_full;
    logic              have_frame;

    logic accept;
    logic last;
    logic wrap;

    assign accept = frame_valid && !pend_full;
    assign last   = (cnt == CBITS'(DWELL - 1));
    assign wrap   = last && (k == KBITS'(NDIG - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            k     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            k     <= k_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        k_n     = k;
        if (!enable) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            k_n     = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (have_frame || accept) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                        k_n     = '0;
                    end
                end
                ST_BLANK: begin
                    // BLANK < DWELL, so the slot never ends while dark
                    cnt_n = cnt + CBITS'(1);
                    if (cnt == CBITS'(BLANK - 1))
                        state_n = ST_SHOW;
                end
                ST_SHOW: begin
                    if (last) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                        k_n     = wrap ? '0 : k + KBITS'(1);
                    end else begin
                        cnt_n = cnt + CBITS'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    k_n     = '0;
                end
            endcase
        end
    end

    // Frame buffers. Swap needs pend_full=1 and accept needs pend_full=0,
    // so the two never collide on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= '0;
            pend_buf   <= '0;
            pend_full  <= 1'b0;
            have_frame <= 1'b0;
        end else begin
            if (enable && state == ST_SHOW && wrap && pend_full) begin
                active    <= pend_buf;
                pend_full <= 1'b0;
            end
            if (accept) begin
                if (state == ST_IDLE) begin
                    // nothing on screen yet, so no tearing risk
                    active     <= frame_data;
                    have_frame <= 1'b1;
                end else begin
                    pend_buf  <= frame_data;
                    pend_full <= 1'b1;
                end
            end
        end
    end

    // Output decode from registered state
    always_comb begin
        segment     = '0;
        digit_en    = '0;
        sig         = 1'b0;
        frame_done  = 1'b0;
        frame_ready = !pend_full;
        if (state == ST_SHOW) begin
            segment    = active[7*int'(k) +: 7];
            digit_en   = NDIG'(1) << k;
            frame_done = wrap;
        end
        if (state == ST_BLANK && cnt == '0)
            sig = 1'b1;
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, DWELL=8, BLANK=2.
// Covers reset, scan timing, back-pressure, boundary accept, enable, async reset.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [27:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [6:0]  segment;
    logic [3:0]  digit_en;
    logic        sig;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    logic [27:0] act;
    logic [27:0] pbuf;
    logic        pend;

    localparam logic [27:0] F1 = 28'h1234567;
    localparam logic [27:0] F2 = 28'h2468ACE;
    localparam logic [27:0] F3 = 28'h13579BD;
    localparam logic [27:0] F4 = 28'h0F0F0F0;
    localparam logic [27:0] F5 = 28'h0555555;
    localparam logic [27:0] F6 = 28'h00C0FFE;

    seg_scan_ctrl #(
        .NDIG (4),
        .DWELL(8),
        .BLANK(2),
        .CBITS(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .segment    (segment),
        .digit_en   (digit_en),
        .sig        (sig),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dark(input string tag, input logic rdy);
        chk({tag, "_seg"}, 32'(segment), 32'h0);
        chk({tag, "_den"}, 32'(digit_en), 32'h0);
        chk({tag, "_sig"}, 32'(sig), 32'h0);
        chk({tag, "_fd"}, 32'(frame_done), 32'h0);
        chk({tag, "_rdy"}, 32'(frame_ready), 32'(rdy));
    endtask

    // Expected outputs at cycle c after leaving IDLE
    task automatic expect_cycle(input int c);
        int slot;
        int ph;
        logic [27:0] dsh;
        slot = (c / 8) % 4;
        ph   = c % 8;
        dsh  = act >> (7 * slot);
        chk($sformatf("sig@%0d", c), 32'(sig), 32'(ph == 0));
        chk($sformatf("den@%0d", c), 32'(digit_en),
            (ph >= 2) ? (32'h1 << slot) : 32'h0);
        chk($sformatf("seg@%0d", c), 32'(segment),
            (ph >= 2) ? 32'(dsh[6:0]) : 32'h0);
        chk($sformatf("fd@%0d", c), 32'(frame_done),
            32'(slot == 3 && ph == 7));
        chk($sformatf("rdy@%0d", c), 32'(frame_ready), 32'(!pend));
    endtask

    // Advance one running edge; returns whether the offer was taken
    task automatic run_edge(input int c, output logic acc);
        acc = frame_valid && !pend;
        if (c % 32 == 31 && pend) begin
            act  = pbuf;
            pend = 1'b0;
        end
        if (acc) begin
            pbuf = frame_data;
            pend = 1'b1;
        end
        tick();
        if (acc)
            frame_valid = 1'b0;
    endtask

    initial begin
        logic acc;
        rst         = 1'b1;
        enable      = 1'b1;
        frame_valid = 1'b0;
        frame_data  = '0;
        act         = '0;
        pbuf        = '0;
        pend        = 1'b0;

        #3;
        chk_dark("rst0", 1'b1);
        tick();
        rst = 1'b0;
        tick();
        chk_dark("idle0", 1'b1);

        #2;
        rst = 1'b1;
        #1;
        chk_dark("rstpulse", 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_dark("noframe", 1'b1);
        end

        // First frame from IDLE goes straight to active
        frame_data  = F1;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        act = F1;

        for (int c = 0; c <= 180; c++) begin
            expect_cycle(c);
            if (c == 2)   chk("f1_d0", 32'(segment), 32'h67);
            if (c == 10)  chk("f1_d1", 32'(segment), 32'h0A);
            if (c == 18)  chk("f1_d2", 32'(segment), 32'h0D);
            if (c == 26)  chk("f1_d3", 32'(segment), 32'h09);
            if (c == 31)  chk("fd31", 32'(frame_done), 32'h1);
            if (c == 63)  chk("rej3_rdy", 32'(frame_ready), 32'h0);
            if (c == 64)  chk("rdy64", 32'(frame_ready), 32'h1);
            if (c == 66)  chk("f2_d0", 32'(segment), 32'h4E);
            if (c == 128) chk("bnd_rdy", 32'(frame_ready), 32'h0);
            if (c == 130) chk("old_rep", 32'(segment), 32'h3D);
            if (c == 162) chk("f4_d0", 32'(segment), 32'h70);
            if (c == 180) break;
            if (c == 40) begin
                frame_data  = F2;
                frame_valid = 1'b1;
            end
            if (c == 48) begin
                frame_data  = F3;
                frame_valid = 1'b1;
            end
            if (c == 127) begin
                frame_data  = F4;
                frame_valid = 1'b1;
            end
            run_edge(c, acc);
        end

        // Drop enable mid-SHOW of slot 2
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_dark("en_off", 1'b1);
        end
        enable = 1'b1;
        tick();
        chk("en_sig", 32'(sig), 32'h1);
        for (int c = 0; c <= 10; c++) begin
            expect_cycle(c);
            if (c == 2) chk("en_same", 32'(segment), 32'h70);
            if (c == 10) break;
            if (c == 9) begin
                frame_data  = F5;
                frame_valid = 1'b1;
            end
            run_edge(c, acc);
        end
        chk("pend_rdy", 32'(frame_ready), 32'h0);

        // Async reset mid-SHOW with a pending frame
        #2;
        rst = 1'b1;
        #1;
        chk_dark("async_rst", 1'b1);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_dark("post_rst", 1'b1);
        end

        frame_data  = F6;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        chk("new_sig", 32'(sig), 32'h1);
        chk("new_den", 32'(digit_en), 32'h0);
        tick();
        tick();
        chk("new_den2", 32'(digit_en), 32'h1);
        chk("new_seg", 32'(segment), 32'h7E);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
